// File: rtl/mem_uart_tx.sv
// mem_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset (release synchronised internally)
//   sel        peripheral select from the system IO decode
//   mem_addr   byte address, only [3:2] decoded: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved
//   mem_rstrb  read strobe
//   mem_wdata  write data
//   mem_wmask  byte write enables
//   mem_rdata  registered read data (1-cycle latency, holds between reads)
//   tx         serial output, idle high, LSB first
//   irq        high while the FIFO is empty and the transmitter is idle
//
// Transmit FSM
//   state   | meaning
//   S_IDLE  | line high; pops the FIFO head into the shift register when data waits
//   S_START | start bit (low) for divisor clocks
//   S_DATA  | eight data bits, shift[0] on the line, divisor clocks each
//   S_STOP  | stop bit (high) for divisor clocks
module mem_uart_tx #(
    parameter int DEFAULT_DIV = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        irq
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state, state_nxt;
    logic [15:0] bit_cnt, cnt_nxt;
    logic [2:0]  bit_idx, idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_nxt;
    logic        pop;

    logic [15:0] divisor;
    logic        overflow;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, busy;
    logic [1:0]  reg_sel;
    logic        data_wr, push, ovf_set, ovf_clr, div_wr;
    logic [31:0] rdata_nxt;

    logic        unused_ok;
    assign unused_ok = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wmask[3:2]};

    // Reset asserts asynchronously but releases on a clock edge, so every
    // flop leaves reset on the same clean edge.
    logic rst_meta, rst_sync_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    assign reg_sel    = mem_addr[3:2];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign busy       = (state != S_IDLE);
    assign irq        = fifo_empty && !busy;

    // Fullness is taken from the registered pointers, so a push against a
    // full FIFO is dropped even if the transmitter pops on the same edge.
    assign data_wr = sel && (reg_sel == 2'd0) && mem_wmask[0];
    assign push    = data_wr && !fifo_full;
    assign ovf_set = data_wr && fifo_full;
    assign ovf_clr = sel && (reg_sel == 2'd1) && mem_wmask[0] && mem_wdata[3];
    assign div_wr  = sel && (reg_sel == 2'd2) && (mem_wmask[1:0] == 2'b11) &&
                     (mem_wdata[15:0] != 16'd0);

    always_comb begin
        rdata_nxt = 32'd0;
        case (reg_sel)
            2'd1:    rdata_nxt = {28'd0, overflow, fifo_empty, fifo_full, busy};
            2'd2:    rdata_nxt = {16'd0, divisor};
            default: rdata_nxt = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            mem_rdata <= 32'd0;
            divisor   <= 16'(DEFAULT_DIV);
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (sel && mem_rstrb) mem_rdata <= rdata_nxt;
            if (div_wr)           divisor   <= mem_wdata[15:0];
            if (ovf_set)          overflow  <= 1'b1;
            else if (ovf_clr)     overflow  <= 1'b0;
            if (push)             wr_ptr    <= wr_ptr + 1'b1;
            if (pop)              rd_ptr    <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= mem_wdata[7:0];
    end

    // tx is registered from the next-state value so the line changes on the
    // same edge as the state, with no combinational path to the pin.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state   <= S_IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end

    // The divisor is sampled only when a bit starts, so a new value takes
    // effect at the next bit boundary.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr[IDX_W-1:0]];
                    cnt_nxt   = divisor - 16'd1;
                    tx_nxt    = 1'b0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_cnt == 16'd0) begin
                    state_nxt = S_DATA;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = divisor - 16'd1;
                    tx_nxt    = shift[0];
                end else begin
                    cnt_nxt = bit_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_cnt == 16'd0) begin
                    cnt_nxt = divisor - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        idx_nxt   = bit_idx + 3'd1;
                        tx_nxt    = shift[1];
                    end
                end else begin
                    cnt_nxt = bit_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_cnt == 16'd0) begin
                    state_nxt = S_IDLE;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = bit_cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_uart_tx.sv
// Directed bench for mem_uart_tx: bus register checks, exact frame timing,
// FIFO/overflow behaviour, divisor change at bit boundary and mid-frame reset.
// A UART receiver process checks each frame against a queue of expected bytes.
module tb_mem_uart_tx;

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_DIV  = 32'h8;
    localparam logic [31:0] A_RSV  = 32'hC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        tx;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    int          rx_div = 16;
    bit          mon_en = 1'b1;

    always #5 clk = ~clk;

    mem_uart_tx #(.DEFAULT_DIV(16), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sel       (sel),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .tx        (tx),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_set(input bit s, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input bit r);
        @(negedge clk);
        sel       = s;
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = r;
    endtask

    task automatic bus_idle();
        bus_set(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_set(1'b1, a, d, m, 1'b0);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_set(1'b1, a, 32'h0, 4'h0, 1'b1);
        bus_idle();
        d = mem_rdata;
    endtask

    task automatic send(input logic [7:0] v, input bit accepted);
        bus_write(A_DATA, {24'h0, v}, 4'h1);
        if (accepted) exp_q.push_back(v);
    endtask

    task automatic wait_fall(input string tag, input int max);
        int n = 0;
        while (tx !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx), 32'd0);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", exp_q.size(), 32'd0);
        repeat (rx_div + 2) @(negedge clk);
        check("irq_after_drain", 32'(irq), 32'd1);
    endtask

    // UART receiver: samples mid-bit at rx_div clocks per bit.
    always begin : uart_mon
        logic [7:0] rx;
        @(negedge clk);
        if (mon_en && reset_n === 1'b1 && tx === 1'b0) begin
            repeat (rx_div / 2) @(negedge clk);
            check("mon_start_bit", 32'(tx), 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (rx_div) @(negedge clk);
                rx[b] = tx;
            end
            repeat (rx_div) @(negedge clk);
            check("mon_stop_bit", 32'(tx), 32'd1);
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_extra_frame observed=0x%0h expected=no frame", rx);
            end
            if (exp_q.size() > 0) check("sb_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
    end

    initial begin : stim
        logic [31:0] rd;
        int          n;
        logic        v;
        logic [31:0] want;

        reset_n   = 1'b0;
        sel       = 1'b0;
        mem_addr  = 32'h0;
        mem_rstrb = 1'b0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state and register map
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd1);
        check("rst_rdata", mem_rdata, 32'd0);
        bus_read(A_STAT, rd); check("rst_status", rd, 32'h4);
        bus_read(A_DATA, rd); check("data_reads_0", rd, 32'h0);
        bus_read(A_RSV, rd);  check("rsv_reads_0", rd, 32'h0);
        bus_read(A_DIV, rd);  check("rst_divisor", rd, 32'd16);

        // Unselected accesses have no effect; rdata holds
        bus_set(1'b0, A_STAT, 32'h0, 4'h0, 1'b1);
        bus_idle();
        check("unsel_read_hold", mem_rdata, 32'd16);
        bus_set(1'b0, A_DIV, 32'd7, 4'hF, 1'b0);
        bus_set(1'b0, A_DATA, 32'hAB, 4'h1, 1'b0);
        bus_idle();
        n = 0;
        while (tx === 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("unsel_write_no_frame", n, 32'd40);
        bus_read(A_DIV, rd); check("unsel_div_write", rd, 32'd16);

        // Read latency: rdata changes only after the strobed edge
        bus_set(1'b1, A_STAT, 32'h0, 4'h0, 1'b1);
        #1 check("rdata_before_edge", mem_rdata, 32'd16);
        bus_idle();
        check("rdata_after_edge", mem_rdata, 32'h4);
        repeat (3) @(negedge clk);
        check("rdata_held", mem_rdata, 32'h4);

        // Exact frame: divisor 4, byte 0x55
        bus_write(A_DIV, 32'd4, 4'h3);
        bus_read(A_DIV, rd); check("div_4", rd, 32'd4);
        rx_div = 4;
        send(8'h55, 1'b1);
        bus_idle();
        wait_fall("frame55_fall", 20);
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       want = 32'd0;
            else if (i < 36) want = 32'((8'h55 >> ((i / 4) - 1)) & 8'h1);
            else             want = 32'd1;
            check("frame55_wave", 32'(tx), want);
            @(negedge clk);
        end
        check("frame55_idle_after", 32'(tx), 32'd1);
        wait_drain(100);

        // Divisor writes that must be ignored
        bus_write(A_DIV, 32'd0, 4'hF);
        bus_read(A_DIV, rd); check("div_zero_ignored", rd, 32'd4);
        bus_write(A_DIV, 32'd9, 4'h1);
        bus_read(A_DIV, rd); check("div_partial_mask_ignored", rd, 32'd4);

        // Five back-to-back bytes into a depth-4 FIFO: all accepted
        bus_write(A_DIV, 32'd16, 4'h3);
        rx_div = 16;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        bus_idle();
        bus_read(A_STAT, rd); check("five_status_busy_no_ovf", rd & 32'h9, 32'h1);
        wait_drain(1500);
        bus_read(A_STAT, rd); check("five_status_end", rd, 32'h4);

        // Six bytes: sixth dropped, overflow sets, then clears
        for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), i < 5);
        bus_idle();
        bus_read(A_STAT, rd);
        check("six_overflow", (rd >> 3) & 32'h1, 32'd1);
        check("six_full", (rd >> 1) & 32'h1, 32'd1);
        check("six_busy", rd & 32'h1, 32'd1);
        bus_write(A_STAT, 32'h8, 4'h1);
        bus_read(A_STAT, rd); check("ovf_cleared", (rd >> 3) & 32'h1, 32'd0);
        wait_drain(1500);
        bus_read(A_STAT, rd); check("six_status_end", rd, 32'h4);

        // Divisor change mid-frame applies from the next bit boundary
        mon_en = 1'b0;
        bus_write(A_DIV, 32'd8, 4'h3);
        send(8'h55, 1'b0);
        bus_idle();
        wait_fall("div8_fall", 20);
        n = 0;
        while (tx === 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("start_len_div8", n, 32'd8);
        n = 0;
        bus_write(A_DIV, 32'd2, 4'h3); n++;
        bus_idle(); n++;
        while (tx === 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("bit0_len_old_div", n, 32'd8);
        for (int k = 1; k < 8; k++) begin
            v = tx;
            check("bit_val", 32'(v), 32'((8'h55 >> k) & 8'h1));
            n = 0;
            while (tx === v && n < 50) begin @(negedge clk); n++; end
            check("bit_len_new_div", n, 32'd2);
        end
        repeat (10) @(negedge clk);
        check("div2_irq_idle", 32'(irq), 32'd1);
        bus_read(A_DIV, rd); check("div_2", rd, 32'd2);

        // Reset during DATA bit 3 with bytes still queued
        bus_write(A_DIV, 32'd16, 4'h3);
        bus_read(A_DIV, rd); check("div_16_pre_reset", rd, 32'd16);
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h0F, 1'b0);
        bus_idle();
        repeat (71) @(negedge clk);
        check("bit3_low_pre_reset", 32'(tx), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("reset_tx_immediate", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd1);
        check("reset_rdata", mem_rdata, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_irq", 32'(irq), 32'd1);
        bus_read(A_STAT, rd); check("post_reset_status", rd, 32'h4);
        bus_read(A_DIV, rd);  check("post_reset_div", rd, 32'd16);
        n = 0;
        while (tx === 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("fifo_discarded", n, 32'd300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
